// File: rtl/stream_minmax_tracker.sv
// Streaming min/max tracker. It accepts unsigned samples over a valid/ready
// handshake and keeps a running maximum, a running minimum and a saturating
// sample count. Every magnitude decision is made by an external sequential
// comparator, which this block loads with operands and then polls for done.
// A comparator stall or a malformed result raises a sticky error flag.
//
// Ports:
//   clk, rst (async, active low), clear (sync, highest priority)
//   in_valid / in_data / in_ready        sample stream
//   cmp_A / cmp_B / cmp_load             comparator operands and start pulse
//   cmp_L / cmp_E / cmp_G / cmp_done     comparator result and done
//   max_val / min_val / sample_count     running statistics
//   have_data, upd_valid, error          status
module stream_minmax_tracker #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] cmp_A,
   output logic [WIDTH-1:0] cmp_B,
   output logic             cmp_load,
   input  logic             cmp_L,
   input  logic             cmp_E,
   input  logic             cmp_G,
   input  logic             cmp_done,
   output logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] min_val,
   output logic [CNT_W-1:0] sample_count,
   output logic             have_data,
   output logic             upd_valid,
   output logic             error
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LD_MAX = 3'd1,
      WT_MAX = 3'd2,
      LD_MIN = 3'd3,
      WT_MIN = 3'd4,
      UPDATE = 3'd5
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] sample, sample_d;
   logic [TW-1:0]    wt_cnt, wt_cnt_d;
   logic             in_ready_d, cmp_load_d, have_data_d, upd_valid_d, error_d;
   logic [WIDTH-1:0] cmp_a_d, cmp_b_d, max_d, min_d;
   logic [CNT_W-1:0] count_d;

   // Result is usable only after the first wait cycle (masks a stale done).
   logic res_seen, res_legal, wt_expired;
   assign res_seen   = cmp_done && (wt_cnt != '0);
   assign res_legal  = $onehot({cmp_L, cmp_E, cmp_G});
   assign wt_expired = (wt_cnt == TW'(TIMEOUT - 1));

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         sample       <= '0;
         wt_cnt       <= '0;
         in_ready     <= 1'b0;
         cmp_A        <= '0;
         cmp_B        <= '0;
         cmp_load     <= 1'b0;
         max_val      <= '0;
         min_val      <= '0;
         sample_count <= '0;
         have_data    <= 1'b0;
         upd_valid    <= 1'b0;
         error        <= 1'b0;
      end else begin
         state        <= state_d;
         sample       <= sample_d;
         wt_cnt       <= wt_cnt_d;
         in_ready     <= in_ready_d;
         cmp_A        <= cmp_a_d;
         cmp_B        <= cmp_b_d;
         cmp_load     <= cmp_load_d;
         max_val      <= max_d;
         min_val      <= min_d;
         sample_count <= count_d;
         have_data    <= have_data_d;
         upd_valid    <= upd_valid_d;
         error        <= error_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state;
      sample_d    = sample;
      wt_cnt_d    = wt_cnt;
      cmp_a_d     = cmp_A;
      cmp_b_d     = cmp_B;
      cmp_load_d  = 1'b0;
      max_d       = max_val;
      min_d       = min_val;
      count_d     = sample_count;
      have_data_d = have_data;
      upd_valid_d = 1'b0;
      error_d     = error;
      in_ready_d  = 1'b0;

      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               sample_d = in_data;
               if (!have_data) begin
                  // First sample seeds both extremes without a comparison.
                  max_d   = in_data;
                  min_d   = in_data;
                  state_d = UPDATE;
               end else begin
                  cmp_a_d    = in_data;
                  cmp_b_d    = max_val;
                  cmp_load_d = 1'b1;
                  state_d    = LD_MAX;
               end
            end
         end
         LD_MAX: begin
            wt_cnt_d = '0;
            state_d  = WT_MAX;
         end
         WT_MAX: begin
            if (res_seen) begin
               if (!res_legal) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end else if (cmp_G) begin
                  // A new maximum cannot also be a new minimum.
                  max_d   = sample;
                  state_d = UPDATE;
               end else begin
                  cmp_a_d    = sample;
                  cmp_b_d    = min_val;
                  cmp_load_d = 1'b1;
                  state_d    = LD_MIN;
               end
            end else if (wt_expired) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               wt_cnt_d = wt_cnt + TW'(1);
            end
         end
         LD_MIN: begin
            wt_cnt_d = '0;
            state_d  = WT_MIN;
         end
         WT_MIN: begin
            if (res_seen) begin
               if (!res_legal) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  if (cmp_L) begin
                     min_d = sample;
                  end
                  state_d = UPDATE;
               end
            end else if (wt_expired) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               wt_cnt_d = wt_cnt + TW'(1);
            end
         end
         UPDATE: begin
            if (sample_count != '1) begin
               count_d = sample_count + CNT_W'(1);
            end
            have_data_d = 1'b1;
            upd_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d = (state_d == IDLE);

      // Clear overrides everything, including a same-cycle handshake.
      if (clear) begin
         state_d     = IDLE;
         sample_d    = '0;
         wt_cnt_d    = '0;
         cmp_a_d     = '0;
         cmp_b_d     = '0;
         cmp_load_d  = 1'b0;
         max_d       = '0;
         min_d       = '0;
         count_d     = '0;
         have_data_d = 1'b0;
         upd_valid_d = 1'b0;
         error_d     = 1'b0;
         in_ready_d  = 1'b0;
      end
   end

endmodule
